cu_sleep_ctrl: RTL and testbench
================================

// Module: cu_sleep_ctrl
// PURPOSE
//   Per-compute-unit sleep-request generator; one instance per CU, upstream of the cache-side power controller.
//   Watches warp activity and CU memory traffic and raises a one-cycle sleep request once the CU has been idle long enough.
//   Holds a delay-sleep flag while memory transactions are still in flight, so the controller does not gate/reset the CU mid-transaction.
// PARAMETERS
//   NUM_WARPS        4   width of warp_active_i
//   MAX_OUTSTANDING  16  max in-flight memory requests tracked (>=1)
//   IDLE_CYCLES      8   consecutive all-idle cycles required before a sleep request (>=1)
// PORTS
//   clk_i            in   1                                  clock
//   rst_ni           in   1                                  async active-low reset
//   cu_rst_n_i       in   1                                  CU reset from controller, same clock domain; 0 = CU held in reset
//   warp_active_i    in   NUM_WARPS                          per-warp active flag from the CU scheduler
//   mem_req_valid_i  in   1                                  CU->memory request valid
//   mem_req_ready_i  in   1                                  CU->memory request ready
//   mem_rsp_valid_i  in   1                                  memory->CU response valid
//   mem_rsp_ready_i  in   1                                  memory->CU response ready
//   sleep_req_o      out  1                                  one-cycle sleep request pulse
//   delay_sleep_o    out  1                                  1 = in-flight traffic, postpone CU reset
//   outstanding_o    out  $clog2(MAX_OUTSTANDING+1)          current in-flight request count
//   err_overflow_o   out  1                                  sticky: request accepted at MAX_OUTSTANDING
//   err_underflow_o  out  1                                  sticky: response accepted at count 0
// BEHAVIOUR
//   Reset (rst_ni=0, async)
//     - FSM=DISARMED, idle cnt=0, outstanding=0.
//     - All outputs 0.
//   FSM (registered; sleep_req_o is a Moore output of SLEEP_REQ)
//     - DISARMED : cu_rst_n_i=1 -> WAIT_ACT.
//     - WAIT_ACT : |warp_active_i -> RUNNING. Never requests sleep before the first warp activity.
//     - RUNNING  : warp_active_i==0 -> IDLE_CNT with cnt=0.
//     - IDLE_CNT : warp_active_i!=0 -> RUNNING, cnt cleared.
//                  Else, if cnt==IDLE_CYCLES-1 -> SLEEP_REQ; otherwise cnt++.
//     - SLEEP_REQ: sleep_req_o=1 for exactly one cycle -> SLEPT. Warp activity in this cycle is ignored.
//     - SLEPT    : waits for cu_rst_n_i=0. No further pulses.
//     - Any state: cu_rst_n_i=0 -> DISARMED next cycle, cnt cleared. Takes priority over all other transitions.
//   Latency: warp_active_i first sampled 0 in RUNNING at cycle 0 and held 0 -> sleep_req_o high in cycle IDLE_CYCLES+1.
//   Outstanding counter (clocked independently of the FSM)
//     - req handshake (valid&ready): +1. rsp handshake: -1. Both in the same cycle: unchanged.
//     - +1 at MAX_OUTSTANDING: saturates, sets err_overflow_o.
//     - -1 at 0 with no simultaneous req: stays 0, sets err_underflow_o.
//     - Not cleared by cu_rst_n_i, so transactions remain tracked across CU reset. Cleared only by rst_ni.
//     - Sticky errors cleared only by rst_ni.
//   delay_sleep_o = (outstanding!=0) | mem_req_valid_i.
//     - Combinational from the registered count and the live valid. Held in every FSM state.
//   outstanding_o is the registered count.
// TESTING
//   1. Defaults. Release rst_ni, cu_rst_n_i=1, warp_active_i=4'b0001 for 5 cyc, then 0
//      -> single sleep_req_o pulse 9 cycles after the first 0 cycle; no second pulse.
//   2. Idle glitch. warp_active_i=0 for 5 cyc, 4'b0100 for 1 cyc, then 0
//      -> count restarts; pulse 9 cycles after the last 0 edge.
//   3. Traffic. 3 req handshakes, then 3 rsp handshakes
//      -> outstanding_o 1,2,3 then 2,1,0; delay_sleep_o=1 until count 0 and valid low.
//   4. Simultaneous events. req+rsp handshake in the same cycle at count 2 -> stays 2.
//      17 reqs with no rsp -> count 16, err_overflow_o=1.
//      rsp at count 0 -> err_underflow_o=1, count 0.
//   5. CU reset. cu_rst_n_i=0 during IDLE_CNT -> no pulse; FSM DISARMED; outstanding_o keeps its value.
//      After release, no pulse until warps go active again.
//   6. Async reset. rst_ni=0 mid-traffic at count 5 -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cu_sleep_ctrl.sv
// Per-CU sleep-request generator: raises a one-cycle sleep pulse after a run of idle
// warp cycles, and flags in-flight memory traffic so the CU is not reset mid-transaction.
module cu_sleep_ctrl #(
    parameter int NUM_WARPS       = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int IDLE_CYCLES     = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 cu_rst_n_i,
    input  logic [NUM_WARPS-1:0]                 warp_active_i,
    input  logic                                 mem_req_valid_i,
    input  logic                                 mem_req_ready_i,
    input  logic                                 mem_rsp_valid_i,
    input  logic                                 mem_rsp_ready_i,
    output logic                                 sleep_req_o,
    output logic                                 delay_sleep_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_overflow_o,
    output logic                                 err_underflow_o
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        DISARMED  = 3'd0,
        WAIT_ACT  = 3'd1,
        RUNNING   = 3'd2,
        IDLE_CNT  = 3'd3,
        SLEEP_REQ = 3'd4,
        SLEPT     = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]    outst_q, outst_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                any_active;
    logic                req_hs, rsp_hs;

    assign any_active = |warp_active_i;
    assign req_hs     = mem_req_valid_i & mem_req_ready_i;
    assign rsp_hs     = mem_rsp_valid_i & mem_rsp_ready_i;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= DISARMED;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // FSM next state; CU reset overrides every other transition
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        if (!cu_rst_n_i) begin
            state_d    = DISARMED;
            idle_cnt_d = '0;
        end else begin
            case (state_q)
                DISARMED: state_d = WAIT_ACT;
                WAIT_ACT: if (any_active) state_d = RUNNING;
                RUNNING: begin
                    if (!any_active) begin
                        state_d    = IDLE_CNT;
                        idle_cnt_d = '0;
                    end
                end
                IDLE_CNT: begin
                    if (any_active) begin
                        state_d    = RUNNING;
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
                        state_d = SLEEP_REQ;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                SLEEP_REQ: state_d = SLEPT;
                SLEPT:     state_d = SLEPT;
                default:   state_d = DISARMED;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        sleep_req_o = (state_q == SLEEP_REQ);
    end

    // Outstanding-transaction tracker, independent of the CU reset
    always_comb begin
        outst_d = outst_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (req_hs && !rsp_hs) begin
            if (outst_q == CNT_W'(MAX_OUTSTANDING)) ovf_d = 1'b1;
            else                                    outst_d = outst_q + 1'b1;
        end else if (rsp_hs && !req_hs) begin
            if (outst_q == '0) unf_d = 1'b1;
            else               outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Gated by rst_ni so a live request valid cannot leak out while in reset
    assign delay_sleep_o   = rst_ni & ((outst_q != '0) | mem_req_valid_i);
    assign outstanding_o   = outst_q;
    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = unf_q;

endmodule

// File: tb/tb_cu_sleep_ctrl.sv
// Directed bench for cu_sleep_ctrl: idle-timer pulse timing, CU reset handling,
// outstanding-count arithmetic with saturation/underflow, and async reset.
module tb_cu_sleep_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cu_rst_n_i;
    logic [3:0] warp_active_i;
    logic       mem_req_valid_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_ready_i;
    logic       sleep_req_o, delay_sleep_o, err_overflow_o, err_underflow_o;
    logic [4:0] outstanding_o;

    int n_cmp = 0;
    int n_err = 0;

    cu_sleep_ctrl #(.NUM_WARPS(4), .MAX_OUTSTANDING(16), .IDLE_CYCLES(8)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cu_rst_n_i      (cu_rst_n_i),
        .warp_active_i   (warp_active_i),
        .mem_req_valid_i (mem_req_valid_i),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_ready_i (mem_rsp_ready_i),
        .sleep_req_o     (sleep_req_o),
        .delay_sleep_o   (delay_sleep_o),
        .outstanding_o   (outstanding_o),
        .err_overflow_o  (err_overflow_o),
        .err_underflow_o (err_underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("check %-22s observed %0h expected %0h", tag, obs, exp);
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (sleep_req_o === 1'b1) pulses++;
        end
    endtask

    // warp_active_i must have just been driven to 0 while RUNNING
    task automatic measure_pulse(input string tag, input int exp_at);
        int at;
        int pulses;
        at = 0;
        pulses = 0;
        for (int i = 1; i <= exp_at + 4; i++) begin
            tick();
            if (sleep_req_o === 1'b1) begin
                pulses++;
                if (at == 0) at = i;
            end
        end
        chk({tag, "_latency"}, at, exp_at);
        chk({tag, "_width"}, pulses, 1);
    endtask

    task automatic set_mem(input logic qv, input logic qr, input logic sv, input logic sr);
        mem_req_valid_i = qv;
        mem_req_ready_i = qr;
        mem_rsp_valid_i = sv;
        mem_rsp_ready_i = sr;
    endtask

    task automatic rearm();
        cu_rst_n_i = 1'b0;
        tick();
        cu_rst_n_i    = 1'b1;
        warp_active_i = 4'b0001;
        repeat (3) tick();
    endtask

    initial begin
        int p;
        rst_ni        = 1'b0;
        cu_rst_n_i    = 1'b1;
        warp_active_i = 4'b0001;
        set_mem(0, 0, 0, 0);
        repeat (2) tick();

        chk("rst_sleep", sleep_req_o, 0);
        chk("rst_delay", delay_sleep_o, 0);
        chk("rst_outst", outstanding_o, 0);
        chk("rst_ovf", err_overflow_o, 0);
        chk("rst_unf", err_underflow_o, 0);

        // 1. default idle timeout
        rst_ni = 1'b1;
        repeat (5) tick();
        warp_active_i = 4'b0000;
        measure_pulse("t1", 9);
        count_pulses(20, p);
        chk("t1_no_second", p, 0);

        // 2. idle glitch restarts the count
        rearm();
        warp_active_i = 4'b0000;
        count_pulses(5, p);
        chk("t2_glitch_nopulse", p, 0);
        warp_active_i = 4'b0100;
        tick();
        warp_active_i = 4'b0000;
        measure_pulse("t2", 9);

        // 3. traffic up/down
        set_mem(1, 0, 0, 0);
        #1 chk("t3_delay_live_valid", delay_sleep_o, 1);
        tick();
        chk("t3_no_hs_cnt", outstanding_o, 0);
        set_mem(1, 1, 0, 0);
        tick(); chk("t3_up1", outstanding_o, 1);
        tick(); chk("t3_up2", outstanding_o, 2);
        tick(); chk("t3_up3", outstanding_o, 3);
        set_mem(0, 0, 1, 1);
        #1 chk("t3_delay_cnt3", delay_sleep_o, 1);
        tick(); chk("t3_dn2", outstanding_o, 2);
        tick(); chk("t3_dn1", outstanding_o, 1);
        chk("t3_delay_cnt1", delay_sleep_o, 1);
        tick(); chk("t3_dn0", outstanding_o, 0);
        set_mem(0, 0, 0, 0);
        #1 chk("t3_delay_idle", delay_sleep_o, 0);

        // 4. simultaneous, overflow, underflow
        set_mem(1, 1, 0, 0);
        repeat (2) tick();
        set_mem(1, 1, 1, 1);
        tick(); chk("t4_both_hold2", outstanding_o, 2);
        set_mem(0, 0, 1, 1);
        repeat (2) tick();
        chk("t4_drain0", outstanding_o, 0);
        set_mem(1, 1, 0, 0);
        repeat (16) tick();
        chk("t4_cnt16", outstanding_o, 16);
        chk("t4_ovf_before", err_overflow_o, 0);
        tick();
        chk("t4_cnt_sat", outstanding_o, 16);
        chk("t4_ovf_set", err_overflow_o, 1);
        set_mem(0, 0, 1, 1);
        repeat (16) tick();
        chk("t4_cnt_drained", outstanding_o, 0);
        chk("t4_unf_before", err_underflow_o, 0);
        tick();
        chk("t4_cnt_floor", outstanding_o, 0);
        chk("t4_unf_set", err_underflow_o, 1);
        chk("t4_ovf_sticky", err_overflow_o, 1);
        set_mem(0, 0, 0, 0);

        // 5. CU reset during IDLE_CNT
        set_mem(1, 1, 0, 0);
        repeat (3) tick();
        set_mem(0, 0, 0, 0);
        rearm();
        warp_active_i = 4'b0000;
        count_pulses(4, p);
        cu_rst_n_i = 1'b0;
        count_pulses(4, p);
        chk("t5_cu_rst_nopulse", p, 0);
        chk("t5_outst_kept", outstanding_o, 3);
        chk("t5_delay_kept", delay_sleep_o, 1);
        cu_rst_n_i = 1'b1;
        count_pulses(20, p);
        chk("t5_wait_act_nopulse", p, 0);
        warp_active_i = 4'b0010;
        repeat (2) tick();
        warp_active_i = 4'b0000;
        measure_pulse("t5", 9);

        // 6. async reset mid-traffic at count 5
        set_mem(1, 1, 0, 0);
        repeat (2) tick();
        chk("t6_cnt5", outstanding_o, 5);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_outst", outstanding_o, 0);
        chk("t6_delay", delay_sleep_o, 0);
        chk("t6_ovf", err_overflow_o, 0);
        chk("t6_unf", err_underflow_o, 0);
        chk("t6_sleep", sleep_req_o, 0);
        set_mem(0, 0, 0, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
